// File: rtl/display_timings_param.sv
// display_timings_param: parametrised raster timing generator.
// Emits position, syncs, data-enable and line/frame strobes per pixel clock.
module display_timings_param #(
    parameter int   CORDW  = 10,
    parameter int   H_RES  = 640,
    parameter int   H_FP   = 16,
    parameter int   H_SYNC = 96,
    parameter int   H_BP   = 48,
    parameter int   V_RES  = 480,
    parameter int   V_FP   = 10,
    parameter int   V_SYNC = 2,
    parameter int   V_BP   = 33,
    parameter logic H_POL  = 1'b0,
    parameter logic V_POL  = 1'b0
) (
    input  logic             clk_pix,
    input  logic             rst,
    input  logic             en,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line,
    output logic             frame,
    output logic             frame_end
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    generate
        if (H_RES == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
            V_RES == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero
            $error("display_timings_param: timing field of zero length");
        end
        if (H_TOTAL > 2**CORDW || V_TOTAL > 2**CORDW) begin : g_ovf
            $error("display_timings_param: total exceeds coordinate range");
        end
    endgenerate

    localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
    localparam logic [CORDW-1:0] HS_ON  = CORDW'(H_RES + H_FP);
    localparam logic [CORDW-1:0] HS_OFF = CORDW'(H_RES + H_FP + H_SYNC);
    localparam logic [CORDW-1:0] VS_ON  = CORDW'(V_RES + V_FP);
    localparam logic [CORDW-1:0] VS_OFF = CORDW'(V_RES + V_FP + V_SYNC);

    logic [CORDW-1:0] nx;
    logic [CORDW-1:0] ny;
    logic             wrap_x;

    // Next position: advance raster order when enabled, otherwise hold.
    always_comb begin
        nx     = sx;
        ny     = sy;
        wrap_x = (sx == H_LAST);
        if (en) begin
            if (wrap_x) begin
                nx = '0;
                ny = (sy == V_LAST) ? '0 : sy + 1'b1;
            end else begin
                nx = sx + 1'b1;
            end
        end
    end

    // Register position and all flags from the next position so they align.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            sx        <= H_LAST;
            sy        <= V_LAST;
            hsync     <= ~H_POL;
            vsync     <= ~V_POL;
            de        <= 1'b0;
            line      <= 1'b0;
            frame     <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            sx        <= nx;
            sy        <= ny;
            hsync     <= (nx >= HS_ON && nx < HS_OFF) ? H_POL : ~H_POL;
            vsync     <= (ny >= VS_ON && ny < VS_OFF) ? V_POL : ~V_POL;
            de        <= (nx < H_ACT) && (ny < V_ACT);
            line      <= en && (nx == '0);
            frame     <= en && (nx == '0) && (ny == '0);
            frame_end <= en && (nx == H_LAST) && (ny == V_LAST);
        end
    end

endmodule

// File: tb/tb_display_timings_param.sv
// tb_display_timings_param: directed vectors, raster walks and a
// random-stall scoreboard over default, small and mid-size modes.
module tb_display_timings_param;

    logic clk_pix = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;

    always #5 clk_pix = ~clk_pix;

    logic [9:0] d_sx, d_sy;
    logic       d_hs, d_vs, d_de, d_ln, d_fr, d_fe;
    logic [3:0] s_sx, s_sy;
    logic       s_hs, s_vs, s_de, s_ln, s_fr, s_fe;
    logic [4:0] m_sx, m_sy;
    logic       m_hs, m_vs, m_de, m_ln, m_fr, m_fe;

    display_timings_param u_def (
        .clk_pix(clk_pix), .rst(rst), .en(en),
        .sx(d_sx), .sy(d_sy), .hsync(d_hs), .vsync(d_vs), .de(d_de),
        .line(d_ln), .frame(d_fr), .frame_end(d_fe)
    );

    display_timings_param #(
        .CORDW(4), .H_RES(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
        .V_RES(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1)
    ) u_sm (
        .clk_pix(clk_pix), .rst(rst), .en(en),
        .sx(s_sx), .sy(s_sy), .hsync(s_hs), .vsync(s_vs), .de(s_de),
        .line(s_ln), .frame(s_fr), .frame_end(s_fe)
    );

    display_timings_param #(
        .CORDW(5), .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_RES(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_mid (
        .clk_pix(clk_pix), .rst(rst), .en(en),
        .sx(m_sx), .sy(m_sy), .hsync(m_hs), .vsync(m_vs), .de(m_de),
        .line(m_ln), .frame(m_fr), .frame_end(m_fe)
    );

    // Mode table for the reference model: default, small, mid.
    localparam int HR[3] = '{640, 4, 16};
    localparam int HF[3] = '{16, 1, 2};
    localparam int HS[3] = '{96, 1, 3};
    localparam int HB[3] = '{48, 2, 4};
    localparam int VR[3] = '{480, 3, 10};
    localparam int VF[3] = '{10, 1, 2};
    localparam int VS[3] = '{2, 1, 2};
    localparam int VB[3] = '{33, 1, 3};
    localparam bit HP[3] = '{1'b0, 1'b1, 1'b0};
    localparam bit VP[3] = '{1'b0, 1'b1, 1'b0};

    logic [9:0] gx[3];
    logic [9:0] gy[3];
    logic [5:0] gf[3];

    assign gx[0] = d_sx;
    assign gx[1] = 10'(s_sx);
    assign gx[2] = 10'(m_sx);
    assign gy[0] = d_sy;
    assign gy[1] = 10'(s_sy);
    assign gy[2] = 10'(m_sy);
    assign gf[0] = {d_hs, d_vs, d_de, d_ln, d_fr, d_fe};
    assign gf[1] = {s_hs, s_vs, s_de, s_ln, s_fr, s_fe};
    assign gf[2] = {m_hs, m_vs, m_de, m_ln, m_fr, m_fe};

    int nvec = 0;
    int nerr = 0;

    int mx[3];
    int my[3];
    bit ml[3];
    bit mf[3];
    bit mfe[3];

    function automatic int ht(input int k);
        return HR[k] + HF[k] + HS[k] + HB[k];
    endfunction

    function automatic int vt(input int k);
        return VR[k] + VF[k] + VS[k] + VB[k];
    endfunction

    // Reference raster position and strobes for each mode.
    always @(posedge clk_pix) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mx[k]  <= ht(k) - 1;
                my[k]  <= vt(k) - 1;
                ml[k]  <= 1'b0;
                mf[k]  <= 1'b0;
                mfe[k] <= 1'b0;
            end else if (en) begin
                mx[k]  <= (mx[k] == ht(k) - 1) ? 0 : mx[k] + 1;
                my[k]  <= (mx[k] != ht(k) - 1) ? my[k] :
                          (my[k] == vt(k) - 1) ? 0 : my[k] + 1;
                ml[k]  <= (mx[k] == ht(k) - 1);
                mf[k]  <= (mx[k] == ht(k) - 1) && (my[k] == vt(k) - 1);
                mfe[k] <= (mx[k] == ht(k) - 2) && (my[k] == vt(k) - 1);
            end else begin
                ml[k]  <= 1'b0;
                mf[k]  <= 1'b0;
                mfe[k] <= 1'b0;
            end
        end
    end

    function automatic logic [5:0] mflags(input int k);
        int  h0;
        int  v0;
        bit  h;
        bit  v;
        bit  d;
        h0 = HR[k] + HF[k];
        v0 = VR[k] + VF[k];
        h  = (mx[k] >= h0 && mx[k] < h0 + HS[k]) ? HP[k] : !HP[k];
        v  = (my[k] >= v0 && my[k] < v0 + VS[k]) ? VP[k] : !VP[k];
        d  = (mx[k] < HR[k]) && (my[k] < VR[k]);
        return {h, v, d, ml[k], mf[k], mfe[k]};
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit e);
        rst = r;
        en  = e;
        @(posedge clk_pix);
        #1;
    endtask

    task automatic sb();
        for (int k = 0; k < 3; k++) begin
            cmp("sb_pos", {gx[k], gy[k]}, {mx[k][9:0], my[k][9:0]});
            cmp("sb_flags", 32'(gf[k]), 32'(mflags(k)));
        end
    endtask

    typedef struct {
        bit         r;
        bit         e;
        logic [3:0] x;
        logic [3:0] y;
        logic [5:0] f;
    } vec_t;

    vec_t tv[16];

    initial begin
        int x;
        int y;
        int cyc;
        int nf;
        int nfe;

        // Small mode: {rst, en, sx, sy, {hs,vs,de,line,frame,frame_end}}
        tv[0]  = '{1'b1, 1'b0, 4'd7, 4'd5, 6'b000000};
        tv[1]  = '{1'b1, 1'b0, 4'd7, 4'd5, 6'b000000};
        tv[2]  = '{1'b1, 1'b0, 4'd7, 4'd5, 6'b000000};
        tv[3]  = '{1'b0, 1'b1, 4'd0, 4'd0, 6'b001110};
        tv[4]  = '{1'b0, 1'b1, 4'd1, 4'd0, 6'b001000};
        tv[5]  = '{1'b0, 1'b0, 4'd1, 4'd0, 6'b001000};
        tv[6]  = '{1'b0, 1'b1, 4'd2, 4'd0, 6'b001000};
        tv[7]  = '{1'b0, 1'b1, 4'd3, 4'd0, 6'b001000};
        tv[8]  = '{1'b0, 1'b1, 4'd4, 4'd0, 6'b000000};
        tv[9]  = '{1'b0, 1'b1, 4'd5, 4'd0, 6'b100000};
        tv[10] = '{1'b0, 1'b1, 4'd6, 4'd0, 6'b000000};
        tv[11] = '{1'b0, 1'b1, 4'd7, 4'd0, 6'b000000};
        tv[12] = '{1'b0, 1'b1, 4'd0, 4'd1, 6'b001100};
        tv[13] = '{1'b0, 1'b0, 4'd0, 4'd1, 6'b001000};
        tv[14] = '{1'b1, 1'b1, 4'd7, 4'd5, 6'b000000};
        tv[15] = '{1'b0, 1'b1, 4'd0, 4'd0, 6'b001110};

        for (int i = 0; i < 16; i++) begin
            step(tv[i].r, tv[i].e);
            cmp($sformatf("vec%0d", i), {s_sx, s_sy, gf[1]},
                {tv[i].x, tv[i].y, tv[i].f});
        end

        // All modes walk together from (0,0) just entered after reset.
        for (int i = 0; i <= 2400; i++) begin
            if (i > 0) step(1'b0, 1'b1);
            x = i % 8;
            y = (i / 8) % 6;
            cmp("sm_walk", {s_sx, s_sy, gf[1]},
                {x[3:0], y[3:0], x == 5, y == 4, x < 4 && y < 3,
                 x == 0, x == 0 && y == 0, x == 7 && y == 5});
            x = i % 800;
            y = i / 800;
            cmp("def_walk", {d_sx, d_sy, gf[0]},
                {x[9:0], y[9:0], !(x >= 656 && x <= 751), 1'b1,
                 x < 640, x == 0, x == 0 && y == 0, 1'b0});
            x = i % 25;
            y = (i / 25) % 17;
            cmp("mid_walk", {m_sx, m_sy, gf[2]},
                {x[4:0], y[4:0], !(x >= 18 && x <= 20),
                 !(y >= 12 && y <= 13), x < 16 && y < 10,
                 x == 0, x == 0 && y == 0, x == 24 && y == 16});
        end

        // Small mode is at (0,0) with frame high: stall 5 cycles there.
        for (int j = 0; j < 5; j++) begin
            step(1'b0, 1'b0);
            cmp("stall_hold", {s_sx, s_sy, s_fr, s_ln, s_de},
                {4'd0, 4'd0, 1'b0, 1'b0, 1'b1});
        end
        step(1'b0, 1'b1);
        cmp("stall_resume", {s_sx, s_sy, s_fr}, {4'd1, 4'd0, 1'b0});
        cyc = 6;
        while (!s_fr && cyc < 100) begin
            step(1'b0, 1'b1);
            cyc++;
        end
        cmp("stall_period", cyc, 53);

        // Reset in the middle of a frame.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        cmp("mrst_sm", {s_sx, s_sy, gf[1]}, {4'd7, 4'd5, 6'b000000});
        cmp("mrst_def", {d_sx, d_sy, gf[0]}, {10'd799, 10'd524, 6'b110000});
        cmp("mrst_mid", {m_sx, m_sy, gf[2]}, {5'd24, 5'd16, 6'b110000});
        step(1'b0, 1'b1);
        cmp("mrst_sm0", {s_sx, s_sy, gf[1]}, {4'd0, 4'd0, 6'b001110});
        cmp("mrst_def0", {d_sx, d_sy, gf[0]}, {10'd0, 10'd0, 6'b111110});
        cmp("mrst_mid0", {m_sx, m_sy, gf[2]}, {5'd0, 5'd0, 6'b111110});

        // Random stalls over three small-mode frames against the model.
        step(1'b1, 1'b0);
        sb();
        nf  = 0;
        nfe = 0;
        cyc = 0;
        while (nfe < 3 && cyc < 2000) begin
            step(1'b0, $urandom_range(0, 3) != 0);
            cyc++;
            sb();
            if (s_fr) nf++;
            if (s_fe) nfe++;
        end
        cmp("rand_frame_ends", nfe, 3);
        cmp("rand_frames", nf, 3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
